// File: rtl/park_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | park_pkg                                                                   |
// | Shared types and helpers for the parking-lot scheduler.                    |
// |   phase_e       : capacity phase of the day (OFF / PEAK / TAPER)           |
// |   HOURS_PER_DAY : hour counter modulus                                     |
// |   HOUR_W        : width of the hour counter                                |
// |   sat0()        : subtraction that saturates at zero                       |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package park_pkg;

   typedef enum logic [1:0] {
      OFF   = 2'd0,
      PEAK  = 2'd1,
      TAPER = 2'd2
   } phase_e;

   localparam int HOURS_PER_DAY = 24;
   localparam int HOUR_W        = 5;

   // a - b, clamped to zero instead of wrapping
   function automatic logic [31:0] sat0(input logic [31:0] a, input logic [31:0] b);
      return (a > b) ? (a - b) : 32'd0;
   endfunction

endpackage
`default_nettype wire

// File: rtl/park_hour_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | park_hour_sched                                                            |
// | Hour-of-day counter with phase FSM and the university reservation it      |
// | implies.                                                                   |
// | Ports:                                                                     |
// |   clk, rst   : clock, asynchronous active-high reset                       |
// |   hour_tick  : advance hour by one, 23 wraps to 0                          |
// |   hour       : current hour 0..23                                          |
// |   uni_cap    : university reservation for the current hour                 |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module park_hour_sched
   import park_pkg::*;
#(
   parameter int CNT_W        = 10,
   parameter int UNI_PEAK_CAP = 500,
   parameter int UNI_OFF_CAP  = 200,
   parameter int TAPER_STEP   = 50,
   parameter int PEAK_START   = 8,
   parameter int TAPER_START  = 13,
   parameter int OFF_START    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              hour_tick,
   output logic [HOUR_W-1:0] hour,
   output logic [CNT_W-1:0]  uni_cap
);

   logic [HOUR_W-1:0] hour_q, hour_d;
   phase_e            phase_q, phase_d;

   function automatic phase_e phase_of(input int h);
      if (h < PEAK_START || h >= OFF_START) return OFF;
      else if (h < TAPER_START)             return PEAK;
      else                                  return TAPER;
   endfunction

   // Reservation shrinks by TAPER_STEP per taper hour, never below the OFF level.
   function automatic logic [CNT_W-1:0] taper_cap(input int h);
      int red;
      red = TAPER_STEP * (h - TAPER_START + 1);
      if (red >= UNI_PEAK_CAP - UNI_OFF_CAP) return CNT_W'(UNI_OFF_CAP);
      else                                   return CNT_W'(UNI_PEAK_CAP - red);
   endfunction

   always_comb begin
      hour_d = hour_q;
      if (hour_tick) begin
         if (hour_q == HOUR_W'(HOURS_PER_DAY - 1)) hour_d = '0;
         else                                      hour_d = hour_q + HOUR_W'(1);
      end
      phase_d = phase_of(int'(hour_d));
   end

   // Phase is registered alongside the hour so both switch on the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hour_q  <= '0;
         phase_q <= phase_of(0);
      end else begin
         hour_q  <= hour_d;
         phase_q <= phase_d;
      end
   end

   always_comb begin
      case (phase_q)
         PEAK:    uni_cap = CNT_W'(UNI_PEAK_CAP);
         TAPER:   uni_cap = taper_cap(int'(hour_q));
         default: uni_cap = CNT_W'(UNI_OFF_CAP);
      endcase
   end

   assign hour = hour_q;

endmodule
`default_nettype wire

// File: rtl/park_ctrl_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | park_ctrl_sched                                                            |
// | University/guest occupancy tracker for one lot with an hour-of-day         |
// | university reservation schedule. Each entry/exit request gets exactly one  |
// | registered ack or nack one cycle later.                                    |
// | Ports:                                                                     |
// |   clk, rst                      : clock, asynchronous active-high reset    |
// |   hour_tick                     : advance the hour counter                 |
// |   enter_req/enter_uni           : entry request and its class (1=uni)      |
// |   exit_req/exit_uni             : exit request and its class               |
// |   enter_ack/nack, exit_ack/nack : registered responses                     |
// |   hour                          : current hour                             |
// |   uni_parked, guest_parked      : occupancy per class                      |
// |   uni_free, guest_free          : free spaces per class                    |
// |   *_has_space                   : free != 0 flags                          |
// | Option: define PARK_STATS_EN to add uni_reject_cnt / guest_reject_cnt,     |
// |   saturating counts of refused entries, cleared at the 23->0 wrap.         |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module park_ctrl_sched
   import park_pkg::*;
#(
   parameter int CNT_W        = 10,
   parameter int TOTAL_CAP    = 700,
   parameter int UNI_PEAK_CAP = 500,
   parameter int UNI_OFF_CAP  = 200,
   parameter int TAPER_STEP   = 50,
   parameter int PEAK_START   = 8,
   parameter int TAPER_START  = 13,
   parameter int OFF_START    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              hour_tick,
   input  logic              enter_req,
   input  logic              enter_uni,
   input  logic              exit_req,
   input  logic              exit_uni,
   output logic              enter_ack,
   output logic              enter_nack,
   output logic              exit_ack,
   output logic              exit_nack,
   output logic [HOUR_W-1:0] hour,
   output logic [CNT_W-1:0]  uni_parked,
   output logic [CNT_W-1:0]  guest_parked,
   output logic [CNT_W-1:0]  uni_free,
   output logic [CNT_W-1:0]  guest_free,
   output logic              uni_has_space,
   output logic              guest_has_space,
`ifdef PARK_STATS_EN
   output logic [CNT_W-1:0]  uni_reject_cnt,
   output logic [CNT_W-1:0]  guest_reject_cnt,
`endif
   output logic              lot_has_space
);

   if (TOTAL_CAP >= (1 << CNT_W) || UNI_PEAK_CAP > TOTAL_CAP) begin : g_param_check
      $error("park_ctrl_sched: capacity parameters do not fit CNT_W or exceed TOTAL_CAP");
   end

   logic [CNT_W-1:0] uni_cap;

   park_hour_sched #(
      .CNT_W        (CNT_W),
      .UNI_PEAK_CAP (UNI_PEAK_CAP),
      .UNI_OFF_CAP  (UNI_OFF_CAP),
      .TAPER_STEP   (TAPER_STEP),
      .PEAK_START   (PEAK_START),
      .TAPER_START  (TAPER_START),
      .OFF_START    (OFF_START)
   ) u_hour_sched (
      .clk       (clk),
      .rst       (rst),
      .hour_tick (hour_tick),
      .hour      (hour),
      .uni_cap   (uni_cap)
   );

   function automatic logic [CNT_W-1:0] uni_free_of(input logic [CNT_W-1:0] cap,
                                                    input logic [CNT_W-1:0] up);
      return CNT_W'(sat0(32'(cap), 32'(up)));
   endfunction

   // Overflow university cars (above a shrunk reservation) keep their spaces,
   // so the guest pool is whatever the larger of cap/occupancy leaves over.
   function automatic logic [CNT_W-1:0] guest_free_of(input logic [CNT_W-1:0] cap,
                                                      input logic [CNT_W-1:0] up,
                                                      input logic [CNT_W-1:0] gp);
      logic [31:0] held;
      held = (up > cap) ? 32'(up) : 32'(cap);
      return CNT_W'(sat0(32'(TOTAL_CAP) - held, 32'(gp)));
   endfunction

   logic [CNT_W-1:0] uni_parked_q, uni_parked_d;
   logic [CNT_W-1:0] guest_parked_q, guest_parked_d;
   logic             enter_ack_q, enter_ack_d, enter_nack_q, enter_nack_d;
   logic             exit_ack_q, exit_ack_d, exit_nack_q, exit_nack_d;
   logic             exit_ok, enter_ok;
   logic [CNT_W-1:0] uni_after, guest_after;

   // Exit is applied first; admission is judged on the post-exit occupancy.
   always_comb begin
      exit_ok = 1'b0;
      if (exit_req) exit_ok = exit_uni ? (uni_parked_q != '0) : (guest_parked_q != '0);
      uni_after   = uni_parked_q   - CNT_W'(exit_ok &&  exit_uni);
      guest_after = guest_parked_q - CNT_W'(exit_ok && !exit_uni);
      enter_ok = enter_uni ? (uni_free_of(uni_cap, uni_after) != '0)
                           : (guest_free_of(uni_cap, uni_after, guest_after) != '0);
      uni_parked_d   = uni_after   + CNT_W'(enter_req && enter_ok &&  enter_uni);
      guest_parked_d = guest_after + CNT_W'(enter_req && enter_ok && !enter_uni);
      enter_ack_d  = enter_req &&  enter_ok;
      enter_nack_d = enter_req && !enter_ok;
      exit_ack_d   = exit_req  &&  exit_ok;
      exit_nack_d  = exit_req  && !exit_ok;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         uni_parked_q   <= '0;
         guest_parked_q <= '0;
         enter_ack_q    <= 1'b0;
         enter_nack_q   <= 1'b0;
         exit_ack_q     <= 1'b0;
         exit_nack_q    <= 1'b0;
      end else begin
         uni_parked_q   <= uni_parked_d;
         guest_parked_q <= guest_parked_d;
         enter_ack_q    <= enter_ack_d;
         enter_nack_q   <= enter_nack_d;
         exit_ack_q     <= exit_ack_d;
         exit_nack_q    <= exit_nack_d;
      end
   end

`ifdef PARK_STATS_EN
   logic [CNT_W-1:0] uni_rej_q, uni_rej_d, guest_rej_q, guest_rej_d;
   logic             day_wrap;

   assign day_wrap = hour_tick && (hour == HOUR_W'(HOURS_PER_DAY - 1));

   // Clear at the wrap takes priority over a same-cycle refusal.
   always_comb begin
      uni_rej_d   = uni_rej_q;
      guest_rej_d = guest_rej_q;
      if (day_wrap) begin
         uni_rej_d   = '0;
         guest_rej_d = '0;
      end else if (enter_nack_d) begin
         if (enter_uni && uni_rej_q != '1)    uni_rej_d   = uni_rej_q + CNT_W'(1);
         if (!enter_uni && guest_rej_q != '1) guest_rej_d = guest_rej_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         uni_rej_q   <= '0;
         guest_rej_q <= '0;
      end else begin
         uni_rej_q   <= uni_rej_d;
         guest_rej_q <= guest_rej_d;
      end
   end

   assign uni_reject_cnt   = uni_rej_q;
   assign guest_reject_cnt = guest_rej_q;
`endif

   assign enter_ack       = enter_ack_q;
   assign enter_nack      = enter_nack_q;
   assign exit_ack        = exit_ack_q;
   assign exit_nack       = exit_nack_q;
   assign uni_parked      = uni_parked_q;
   assign guest_parked    = guest_parked_q;
   assign uni_free        = uni_free_of(uni_cap, uni_parked_q);
   assign guest_free      = guest_free_of(uni_cap, uni_parked_q, guest_parked_q);
   assign uni_has_space   = (uni_free != '0);
   assign guest_has_space = (guest_free != '0);
   assign lot_has_space   = uni_has_space | guest_has_space;

endmodule
`default_nettype wire
